// File: rtl/alice_pkg.sv
// Shared definitions for the Alice demux sequencer and the demux that consumes its select.
// The idle code is shared so both ends agree on the "no output" select value.
package alice_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_SLOT_W = 8;
  localparam logic [1:0] IDLE_CODE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [1:0] dataSel(input logic keyBit);
    return {1'b0, keyBit};
  endfunction

endpackage

// File: rtl/alice_demux_sequencer_if.sv
// Key-word handshake between the word source (master) and the sequencer (slave).
interface alice_demux_sequencer_if import alice_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int SLOT_W = DEF_SLOT_W
);

  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;
  logic [SLOT_W-1:0] slot_len;
  logic [SLOT_W-1:0] gap_len;

  modport master (output word_valid, word_data, slot_len, gap_len, input word_ready);
  modport slave  (input word_valid, word_data, slot_len, gap_len, output word_ready);

endinterface

// File: rtl/alice_slot_timer.sv
// Loadable phase counter shared by the data and gap phases; tc flags the last cycle of a phase.
module alice_slot_timer import alice_pkg::*; #(
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [SLOT_W-1:0] term,
  output logic              tc
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/alice_demux_sequencer.sv
// Serialises key words LSB first onto the Alice demux select, one data slot plus an optional
// idle gap per bit, with a one-word holding register so consecutive words stream back to back.
module alice_demux_sequencer import alice_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int SLOT_W = DEF_SLOT_W,
  localparam int IDX_W = $clog2(WORD_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  alice_demux_sequencer_if.slave  word_if,
  output logic [1:0]              demux_sel,
  output logic                    busy,
  output logic [IDX_W-1:0]        bit_idx,
  output logic                    word_done
);

  state_e            state_q;
  logic [WORD_W-1:0] shiftReg_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] gap_q;
  logic [IDX_W-1:0]  bitIdx_q;
  logic [1:0]        demuxSel_q;
  logic              wordDone_q;

  logic              holdValid_q;
  logic              holdValid_d;
  logic [WORD_W-1:0] holdData_q;
  logic [SLOT_W-1:0] holdSlot_q;
  logic [SLOT_W-1:0] holdGap_q;

  logic              takeWord;
  logic              loadHold;
  logic              bitEnd;
  logic              lastBit;
  logic              termHit;
  logic              timerEn;
  logic              timerClear;
  logic [SLOT_W-1:0] termCnt;

  assign word_if.word_ready = !holdValid_q;
  assign takeWord = word_if.word_valid && !holdValid_q;
  assign lastBit  = (bitIdx_q == IDX_W'(WORD_W - 1));
  assign bitEnd   = enable && termHit &&
                    ((state_q == ST_DATA && gap_q == '0) || state_q == ST_GAP);
  // A queued word is taken either from idle or on the closing edge of the previous word.
  assign loadHold = enable && holdValid_q && (state_q == ST_IDLE || (bitEnd && lastBit));

  always_comb begin
    termCnt = '0;
    if (state_q == ST_GAP) begin
      termCnt = gap_q - SLOT_W'(1);
    end else if (slot_q != '0) begin
      termCnt = slot_q - SLOT_W'(1);
    end
  end

  assign timerEn    = enable && (state_q != ST_IDLE);
  assign timerClear = enable && (state_q == ST_IDLE || termHit);

  alice_slot_timer #(.SLOT_W(SLOT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (timerEn),
    .clear (timerClear),
    .term  (termCnt),
    .tc    (termHit)
  );

  always_comb begin
    holdValid_d = holdValid_q;
    if (takeWord) begin
      holdValid_d = 1'b1;
    end else if (loadHold) begin
      holdValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      holdSlot_q  <= '0;
      holdGap_q   <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      if (takeWord) begin
        holdData_q <= word_if.word_data;
        holdSlot_q <= word_if.slot_len;
        holdGap_q  <= word_if.gap_len;
      end
    end
  end

  // Pausing freezes everything except the holding register and suppresses word_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shiftReg_q <= '0;
      slot_q     <= '0;
      gap_q      <= '0;
      bitIdx_q   <= '0;
      demuxSel_q <= IDLE_CODE;
      wordDone_q <= 1'b0;
    end else if (!enable) begin
      wordDone_q <= 1'b0;
    end else begin
      wordDone_q <= bitEnd && lastBit;
      if (loadHold) begin
        shiftReg_q <= holdData_q;
        slot_q     <= holdSlot_q;
        gap_q      <= holdGap_q;
        bitIdx_q   <= '0;
        state_q    <= ST_DATA;
        demuxSel_q <= dataSel(holdData_q[0]);
      end else if (bitEnd && !lastBit) begin
        shiftReg_q <= shiftReg_q >> 1;
        bitIdx_q   <= bitIdx_q + IDX_W'(1);
        state_q    <= ST_DATA;
        demuxSel_q <= dataSel(shiftReg_q[1]);
      end else if (bitEnd) begin
        bitIdx_q   <= '0;
        state_q    <= ST_IDLE;
        demuxSel_q <= IDLE_CODE;
      end else if (state_q == ST_DATA && termHit) begin
        state_q    <= ST_GAP;
        demuxSel_q <= IDLE_CODE;
      end
    end
  end

  assign demux_sel = demuxSel_q;
  assign busy      = (state_q != ST_IDLE);
  assign bit_idx   = bitIdx_q;
  assign word_done = wordDone_q;

endmodule

// File: tb/tb_alice_demux_sequencer.sv
// Directed bench for the Alice demux sequencer: bit timing, back-to-back words, pause and reset.
module tb_alice_demux_sequencer;
  import alice_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] demux_sel;
  logic       busy;
  logic [3:0] bit_idx;
  logic       word_done;

  int checks = 0;
  int errors = 0;
  bit pendingOffer = 1'b0;

  alice_demux_sequencer_if wif ();

  alice_demux_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .word_if   (wif),
    .demux_sel (demux_sel),
    .busy      (busy),
    .bit_idx   (bit_idx),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [7:0] s, input logic [7:0] g);
    wif.word_valid = v;
    wif.word_data  = d;
    wif.slot_len   = s;
    wif.gap_len    = g;
  endtask

  // Advance one clock and sample 1 time unit later; retire any outstanding word offer.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pendingOffer) begin
      checkOutput("offer_accepted", 32'(wif.word_ready), 32'd0);
      wif.word_valid = 1'b0;
      pendingOffer   = 1'b0;
    end
  endtask

  // From idle: offer a word, see it sit in the holding register, then land on its first slot.
  task automatic startFromIdle(input logic [15:0] w, input logic [7:0] s, input logic [7:0] g, input string tag);
    applyStimulus(1'b1, w, s, g);
    tick();
    checkOutput({tag, "_hold_ready"}, 32'(wif.word_ready), 32'd0);
    checkOutput({tag, "_hold_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_hold_sel"}, 32'(demux_sel), 32'd3);
    applyStimulus(1'b0, w, s, g);
    tick();
  endtask

  // Caller is already at the first sample of the word; walks every slot of all 16 bits.
  task automatic streamWord(input logic [15:0] w, input int slotEff, input int gap,
                            input int offerK, input logic [15:0] nw, input logic [7:0] ns,
                            input logic [7:0] ng, input int pauseK, input int pauseLen,
                            input string tag);
    int period;
    int expIdx;
    logic [1:0] expSel;
    period = slotEff + gap;
    for (int k = 0; k < period * 16; k++) begin
      if (k > 0) tick();
      expIdx = k / period;
      expSel = ((k % period) < slotEff) ? {1'b0, w[expIdx]} : 2'b11;
      checkOutput({tag, "_sel"}, 32'(demux_sel), 32'(expSel));
      checkOutput({tag, "_idx"}, 32'(bit_idx), 32'(expIdx));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      if (k > 0) checkOutput({tag, "_done_low"}, 32'(word_done), 32'd0);
      if (k == offerK) begin
        applyStimulus(1'b1, nw, ns, ng);
        pendingOffer = 1'b1;
      end
      if (k == pauseK) begin
        enable = 1'b0;
        for (int p = 0; p < pauseLen; p++) begin
          tick();
          checkOutput({tag, "_pause_sel"}, 32'(demux_sel), 32'(expSel));
          checkOutput({tag, "_pause_idx"}, 32'(bit_idx), 32'(expIdx));
          checkOutput({tag, "_pause_done"}, 32'(word_done), 32'd0);
        end
        enable = 1'b1;
      end
    end
  endtask

  task automatic checkWordEnd(input bit chained, input logic nextBit0, input string tag);
    tick();
    checkOutput({tag, "_done"}, 32'(word_done), 32'd1);
    if (chained) begin
      checkOutput({tag, "_chain_sel"}, 32'(demux_sel), 32'({1'b0, nextBit0}));
      checkOutput({tag, "_chain_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_chain_idx"}, 32'(bit_idx), 32'd0);
    end else begin
      checkOutput({tag, "_idle_sel"}, 32'(demux_sel), 32'd3);
      checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_idle_ready"}, 32'(wif.word_ready), 32'd1);
      tick();
      checkOutput({tag, "_done_pulse"}, 32'(word_done), 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    applyStimulus(1'b0, 16'h0000, 8'd0, 8'd0);
    tick();
    tick();
    checkOutput("reset_sel", 32'(demux_sel), 32'd3);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(wif.word_ready), 32'd1);
    checkOutput("reset_done", 32'(word_done), 32'd0);
    checkOutput("reset_idx", 32'(bit_idx), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] word F99B slot 1 gap 1, word 0001 queued behind it");
    startFromIdle(16'hF99B, 8'd1, 8'd1, "w1");
    checkOutput("w1_first_sel", 32'(demux_sel), 32'd1);
    streamWord(16'hF99B, 1, 1, 0, 16'h0001, 8'd1, 8'd1, -1, 0, "w1");
    checkWordEnd(1'b1, 1'b1, "w1_end");
    streamWord(16'h0001, 1, 1, -1, 16'h0000, 8'd0, 8'd0, -1, 0, "w2");
    checkWordEnd(1'b0, 1'b0, "w2_end");

    $display("[TB] word 00FF slot 3 gap 0");
    startFromIdle(16'h00FF, 8'd3, 8'd0, "w3");
    streamWord(16'h00FF, 3, 0, -1, 16'h0000, 8'd0, 8'd0, -1, 0, "w3");
    checkWordEnd(1'b0, 1'b0, "w3_end");

    $display("[TB] word A5C3 slot 4 gap 1 paused in bit 7, word 6E21 slot 0 gap 2 queued");
    startFromIdle(16'hA5C3, 8'd4, 8'd1, "w4");
    streamWord(16'hA5C3, 4, 1, 37, 16'h6E21, 8'd0, 8'd2, 37, 5, "w4");
    checkWordEnd(1'b1, 1'b1, "w4_end");
    streamWord(16'h6E21, 1, 2, -1, 16'h0000, 8'd0, 8'd0, -1, 0, "w5");
    checkWordEnd(1'b0, 1'b0, "w5_end");

    $display("[TB] asynchronous reset mid-word with a word held");
    startFromIdle(16'h1234, 8'd2, 8'd1, "w6");
    tick();
    tick();
    applyStimulus(1'b1, 16'h5555, 8'd1, 8'd1);
    tick();
    checkOutput("w6_hold_full", 32'(wif.word_ready), 32'd0);
    applyStimulus(1'b0, 16'h0000, 8'd0, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_sel", 32'(demux_sel), 32'd3);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_ready", 32'(wif.word_ready), 32'd1);
    checkOutput("async_rst_done", 32'(word_done), 32'd0);
    checkOutput("async_rst_idx", 32'(bit_idx), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_sel", 32'(demux_sel), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
